// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, HALT encoding, fetch FSM states and
// the next-PC selector codes used between the fetch unit and its PC mux.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam word_t HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2
  } pc_sel_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic word_t align_word(input word_t addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch-stage signals with views for the fetch unit itself,
// the control unit that consumes IF/ID and redirects, and the icache.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iREN;
  word_t iaddr;
  logic  stall;
  logic  pc_src;
  word_t target;
  word_t instr;
  logic  instr_valid;
  word_t npc;
  logic  halt;

  modport fu (
    input  ihit, iload, stall, pc_src, target,
    output iREN, iaddr, instr, instr_valid, npc, halt
  );

  modport cu (
    input  instr, instr_valid, npc, halt,
    output stall, pc_src, target
  );

  modport ic (
    input  iREN, iaddr,
    output ihit, iload
  );

endinterface

// File: rtl/fetch_pc_sel.sv
// Combinational next-PC mux: hold, sequential PC+4, or aligned redirect.
module fetch_pc_sel
  import cpu_types_pkg::*;
(
  input  pc_sel_t sel,
  input  word_t   pc,
  input  word_t   target,
  output word_t   pc_plus4,
  output word_t   pc_next
);

  // PC+4 wraps modulo 2^32 without any overflow indication.
  assign pc_plus4 = pc + 32'd4;

  // Pick the PC for the next cycle based on the fetch unit's decision.
  always_comb begin
    pc_next = pc;
    case (sel)
      PC_INC:    pc_next = pc_plus4;
      PC_TARGET: pc_next = align_word(target);
      default:   pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from the icache,
// registers instr/PC+4 into IF/ID, follows redirects and parks on HALT.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] target,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] npc,
  output logic        halt
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        instr_q, instr_d;
  word_t        npc_q, npc_d;
  logic         valid_q, valid_d;
  pc_sel_t      pc_sel;
  word_t        pc_plus4;

  fetch_pc_sel u_pc_sel (
    .sel      (pc_sel),
    .pc       (pc_q),
    .target   (target),
    .pc_plus4 (pc_plus4),
    .pc_next  (pc_d)
  );

  // Next-state decision: redirect beats stall, stall freezes IF/ID,
  // a hit advances the PC, a miss inserts a bubble.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    pc_sel  = PC_HOLD;
    case (state_q)
      FETCH: begin
        if (pc_src) begin
          pc_sel  = PC_TARGET;
          valid_d = 1'b0;
        end else if (!stall) begin
          if (ihit) begin
            pc_sel  = PC_INC;
            instr_d = iload;
            npc_d   = pc_plus4;
            valid_d = 1'b1;
            if (iload == HALT_WORD) begin
              state_d = HALTED;
            end
          end else begin
            valid_d = 1'b0;
          end
        end
      end
      HALTED: begin
        if (!stall) begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Register the PC, FSM state and the IF/ID boundary.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign iREN        = !RST && (state_q == FETCH) && !stall;
  assign iaddr       = pc_q;
  assign halt        = (state_q == HALTED);
  assign instr       = instr_q;
  assign npc         = npc_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by random traffic,
// all compared against a behavioural model of the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam logic [31:0] HALT    = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall;
  logic        pc_src;
  logic [31:0] target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] npc;
  logic        halt;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m_pc, m_instr, m_npc;
  logic        m_valid, m_halted;

  fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .iload       (iload),
    .iREN        (iREN),
    .iaddr       (iaddr),
    .stall       (stall),
    .pc_src      (pc_src),
    .target      (target),
    .instr       (instr),
    .instr_valid (instr_valid),
    .npc         (npc),
    .halt        (halt)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = PC_INIT; m_instr = 32'h0; m_npc = 32'h0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // One clock edge of the fetch stage as described by its rules.
  task automatic model_step();
    if (RST) begin
      model_reset();
    end else if (m_halted) begin
      if (!stall) m_valid = 1'b0;
    end else if (pc_src) begin
      m_pc    = {target[31:2], 2'b00};
      m_valid = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (ihit) begin
      m_instr = iload;
      m_npc   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      if (iload == HALT) m_halted = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic checkComb();
    chk("iREN",  {31'b0, iREN}, {31'b0, (!RST && !m_halted && !stall)});
    chk("iaddr", iaddr, m_pc);
    chk("halt",  {31'b0, halt}, {31'b0, m_halted});
  endtask

  task automatic checkOutput();
    chk("instr",       instr, m_instr);
    chk("npc",         npc, m_npc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
    chk("halt_reg",    {31'b0, halt}, {31'b0, m_halted});
  endtask

  task automatic applyStimulus(input logic r, input logic h, input logic s, input logic p,
                               input logic [31:0] ld, input logic [31:0] tg);
    RST = r; ihit = h; stall = s; pc_src = p; iload = ld; target = tg;
    #2;
    checkComb();
    @(posedge CLK);
    model_step();
    #1;
    checkOutput();
  endtask

  // Directed scenarios, then randomized traffic, then the summary.
  initial begin
    int halted_cycles;
    logic r, h, s, p;
    logic [31:0] ld, tg;

    RST = 1'b1; ihit = 1'b0; stall = 1'b0; pc_src = 1'b0; iload = '0; target = '0;
    repeat (2) @(posedge CLK);
    model_reset();
    #1;

    // Reset held: iREN low, reset values.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0);
    chk("rst_iaddr", iaddr, PC_INIT);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);

    // Back-to-back hits from PC_INIT.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h2001_0001, 32'h0);
    chk("seq_instr0", instr, 32'h2001_0001);
    chk("seq_npc0",   npc, 32'h4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h2002_0002, 32'h0);
    chk("seq_npc1",   npc, 32'h8);
    chk("seq_iaddr2", iaddr, 32'h8);

    // Miss for 3 cycles at 0x10.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h10);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0);
      chk("miss_iaddr", iaddr, 32'h10);
      chk("miss_valid", {31'b0, instr_valid}, 32'h0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h2003_0003, 32'h0);
    chk("miss_npc", npc, 32'h14);

    // Redirect to 0x43 while hitting at 0x20.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h20);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h2004_0004, 32'h43);
    chk("redir_iaddr", iaddr, 32'h40);
    chk("redir_valid", {31'b0, instr_valid}, 32'h0);

    // Stall two cycles with ihit high.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h2005_0005, 32'h0);
      chk("stall_iREN",  {31'b0, iREN}, 32'h0);
      chk("stall_iaddr", iaddr, 32'h40);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h2006_0006, 32'h0);
    chk("stall_resume_instr", instr, 32'h2006_0006);

    // PC wrap at the top of memory.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h2007_0007, 32'h0);
    chk("wrap_npc",   npc, 32'h0);
    chk("wrap_iaddr", iaddr, 32'h0);

    // HALT squashed by a same-cycle redirect.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h8);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, HALT, 32'h100);
    chk("halt_squash",  {31'b0, halt}, 32'h0);
    chk("halt_sq_addr", iaddr, 32'h100);

    // HALT taken at 0x8, front end parks.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h8);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, HALT, 32'h0);
    chk("halt_set",   {31'b0, halt}, 32'h1);
    chk("halt_instr", instr, HALT);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h2008_0008, 32'h200);
      chk("halted_iREN", {31'b0, iREN}, 32'h0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("halt_rst_iaddr", iaddr, PC_INIT);
    chk("halt_rst_halt",  {31'b0, halt}, 32'h0);

    // Randomized traffic against the model.
    halted_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0) || (halted_cycles > 4);
      h  = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 4) == 0);
      p  = ($urandom_range(0, 9) == 0);
      ld = ($urandom_range(0, 29) == 0) ? HALT : $urandom;
      tg = $urandom;
      applyStimulus(r, h, s, p, ld, tg);
      halted_cycles = m_halted ? halted_cycles + 1 : 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
